// File: rtl/scan_pkg.sv
// Shared types for the block scan generator: scan mode, FSM state
// and the final scan index N*N-1 for a given log2 block side.
package scan_pkg;

  typedef enum logic {
    SCAN_RASTER = 1'b0,
    SCAN_ZIGZAG = 1'b1
  } scan_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } scan_state_e;

  function automatic int unsigned final_idx(
    input int unsigned n_log2
  );
    return (32'd1 << (2 * n_log2)) - 32'd1;
  endfunction

endpackage

// File: rtl/en_dff.sv
// Enable flop cell with synchronous active-high reset.
// Ports: clk, rst, en, d[W] -> q[W]; q resets to RST_VAL.
module en_dff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)     q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/zigzag_step.sv
// Combinational JPEG zigzag successor of (u, v) in an N x N block.
// Ports: u, v (current) -> u_nx, v_nx (next position in zigzag order).
module zigzag_step #(
  parameter int N_LOG2 = 3
) (
  input  logic [N_LOG2-1:0] u,
  input  logic [N_LOG2-1:0] v,
  output logic [N_LOG2-1:0] u_nx,
  output logic [N_LOG2-1:0] v_nx
);

  localparam logic [N_LOG2-1:0] MAXC = '1;

  logic odd;
  logic u_max, v_max, u_zero, v_zero;

  // Parity of u+v equals parity of the two LSBs.
  assign odd    = u[0] ^ v[0];
  assign u_max  = (u == MAXC);
  assign v_max  = (v == MAXC);
  assign u_zero = (u == '0);
  assign v_zero = (v == '0);

  always_comb begin
    u_nx = u;
    v_nx = v;
    unique case (1'b1)
      (!odd &&  u_max):
        v_nx = v + 1'b1;
      (!odd && !u_max &&  v_zero):
        u_nx = u + 1'b1;
      (!odd && !u_max && !v_zero): begin
        u_nx = u + 1'b1;
        v_nx = v - 1'b1;
      end
      ( odd &&  v_max):
        u_nx = u + 1'b1;
      ( odd && !v_max &&  u_zero):
        v_nx = v + 1'b1;
      ( odd && !v_max && !u_zero): begin
        u_nx = u - 1'b1;
        v_nx = v + 1'b1;
      end
      default: begin
        u_nx = u;
        v_nx = v;
      end
    endcase
  end

endmodule

// File: rtl/block_scan_gen.sv
// Coefficient-position generator: walks an N x N block in raster or
// zigzag order, one (u, v, idx) per valid/ready beat; done pulses after
// the final beat. Zigzag support compiled in with BLOCK_SCAN_ZIGZAG_EN.
// Ports: clk, rst, start, mode, abort, ready ->
//        u, v, idx, valid, last, busy, done (all registered).
module block_scan_gen
  import scan_pkg::*;
#(
  parameter int N_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  abort,
  input  logic                  ready,
  output logic [N_LOG2-1:0]     u,
  output logic [N_LOG2-1:0]     v,
  output logic [2*N_LOG2-1:0]   idx,
  output logic                  valid,
  output logic                  last,
  output logic                  busy,
  output logic                  done
);

  localparam int W  = N_LOG2;
  localparam int IW = 2 * N_LOG2;
  localparam logic [W-1:0]  MAXC     = '1;
  localparam logic [IW-1:0] LAST_IDX = IW'(final_idx(N_LOG2));

  scan_state_e state_q, state_d;

  logic [W-1:0]  u_q, v_q;
  logic [W-1:0]  u_d, v_d;
  logic [W-1:0]  u_rs, v_rs;
  logic [W-1:0]  u_step, v_step;
  logic [IW-1:0] idx_q, idx_d;
  logic          last_q, last_d;
  logic          done_q, done_d;
  logic          run, load, beat, final_beat, adv, en_pos;

  assign run        = (state_q == ST_RUN);
  // abort wins over a same-cycle handshake
  assign beat       = run & ready & ~abort;
  assign final_beat = beat & last_q;
  assign load       = (state_q == ST_IDLE) & start;
  // the final beat must not move the position off (N-1, N-1)
  assign adv        = beat & ~last_q;
  assign en_pos     = load | adv;

  assign u_rs = u_q + 1'b1;
  assign v_rs = (u_q == MAXC) ? v_q + 1'b1 : v_q;

`ifdef BLOCK_SCAN_ZIGZAG_EN
  logic          mode_q;
  logic [W-1:0]  u_zz, v_zz;
  logic          zz_sel;

  en_dff #(
    .W       (1),
    .RST_VAL (1'(SCAN_RASTER))
  ) u_mode_ff (
    .clk (clk),
    .rst (rst),
    .en  (load),
    .d   (mode),
    .q   (mode_q)
  );

  zigzag_step #(
    .N_LOG2 (N_LOG2)
  ) u_zigzag_step (
    .u    (u_q),
    .v    (v_q),
    .u_nx (u_zz),
    .v_nx (v_zz)
  );

  assign zz_sel = (scan_mode_e'(mode_q) == SCAN_ZIGZAG);
  assign u_step = zz_sel ? u_zz : u_rs;
  assign v_step = zz_sel ? v_zz : v_rs;
`else
  logic unused_mode;

  assign unused_mode = mode;
  assign u_step      = u_rs;
  assign v_step      = v_rs;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (abort || final_beat) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // next values for the registered outputs
  always_comb begin
    u_d    = load ? '0 : u_step;
    v_d    = load ? '0 : v_step;
    idx_d  = load ? '0 : idx_q + 1'b1;
    done_d = final_beat;
    last_d = last_q;
    if (load) begin
      last_d = 1'b0;
    end else if (run) begin
      if (abort || final_beat) last_d = 1'b0;
      else if (beat)           last_d = (idx_d == LAST_IDX);
    end
  end

  en_dff #(.W(W)) u_u_ff (
    .clk (clk),
    .rst (rst),
    .en  (en_pos),
    .d   (u_d),
    .q   (u_q)
  );

  en_dff #(.W(W)) u_v_ff (
    .clk (clk),
    .rst (rst),
    .en  (en_pos),
    .d   (v_d),
    .q   (v_q)
  );

  en_dff #(.W(IW)) u_idx_ff (
    .clk (clk),
    .rst (rst),
    .en  (en_pos),
    .d   (idx_d),
    .q   (idx_q)
  );

  en_dff #(.W(1)) u_last_ff (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .d   (last_d),
    .q   (last_q)
  );

  en_dff #(.W(1)) u_done_ff (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .d   (done_d),
    .q   (done_q)
  );

  assign u     = u_q;
  assign v     = v_q;
  assign idx   = idx_q;
  assign valid = run;
  assign busy  = run;
  assign last  = last_q;
  assign done  = done_q;

endmodule

// File: tb/tb_block_scan_gen.sv
// Scoreboard bench for block_scan_gen: N_LOG2=3 and N_LOG2=1 instances,
// directed raster/zigzag/abort/restart/reset scenarios.
`timescale 1ns/1ps
module tb_block_scan_gen;

  typedef struct packed {
    logic [7:0]  u;
    logic [7:0]  v;
    logic [15:0] idx;
    logic        last;
  } beat_t;

`ifdef BLOCK_SCAN_ZIGZAG_EN
  localparam bit ZZ_EN = 1'b1;
  int hu[11] = '{0, 1, 0, 0, 1, 2, 3, 2, 1, 0, 0};
  int hv[11] = '{0, 0, 1, 2, 1, 0, 0, 1, 2, 3, 4};
`else
  localparam bit ZZ_EN = 1'b0;
  int hu[11] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
  int hv[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start3, mode3, abort3, ready3;
  logic [2:0] u3, v3;
  logic [5:0] idx3;
  logic       valid3, last3, busy3, done3;

  logic       start1, mode1, abort1, ready1;
  logic [0:0] u1, v1;
  logic [1:0] idx1;
  logic       valid1, last1, busy1, done1;

  block_scan_gen #(.N_LOG2(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .mode(mode3),
    .abort(abort3), .ready(ready3), .u(u3), .v(v3), .idx(idx3),
    .valid(valid3), .last(last3), .busy(busy3), .done(done3)
  );

  block_scan_gen #(.N_LOG2(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode1),
    .abort(abort1), .ready(ready1), .u(u1), .v(v1), .idx(idx1),
    .valid(valid1), .last(last1), .busy(busy1), .done(done1)
  );

  int checks = 0;
  int errors = 0;
  beat_t exp3[$];
  beat_t exp1[$];
  bit rnd_ready3 = 1'b0;
  int lu3[64];
  int lv3[64];
  int seen3[64];
  bit stall3 = 1'b0;
  beat_t held3;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Expected walk built by enumerating rows / anti-diagonals.
  task automatic gen(input int nl, input bit zz, input int cnt,
                     output beat_t q[$]);
    int n;
    int k;
    int lo;
    int hi;
    beat_t b;
    n = 1 << nl;
    k = 0;
    q = {};
    if (!zz) begin
      for (int vv = 0; vv < n; vv++)
        for (int uu = 0; uu < n; uu++) begin
          b.u = 8'(uu); b.v = 8'(vv); b.idx = 16'(k);
          b.last = (k == n * n - 1);
          if (k < cnt) q.push_back(b);
          k++;
        end
    end else begin
      for (int d = 0; d <= 2 * n - 2; d++) begin
        lo = (d - n + 1 > 0) ? d - n + 1 : 0;
        hi = (d < n - 1) ? d : n - 1;
        for (int j = 0; j <= hi - lo; j++) begin
          int uu;
          uu = (d % 2 == 1) ? hi - j : lo + j;
          b.u = 8'(uu); b.v = 8'(d - uu); b.idx = 16'(k);
          b.last = (k == n * n - 1);
          if (k < cnt) q.push_back(b);
          k++;
        end
      end
    end
  endtask

  task automatic push3(input bit zz, input int cnt);
    beat_t q[$];
    gen(3, zz, cnt, q);
    foreach (q[i]) exp3.push_back(q[i]);
  endtask

  task automatic drain(input bit which, input int maxc, input string nm);
    int c;
    c = 0;
    while (((which ? exp1.size() : exp3.size()) != 0) && c < maxc) begin
      @(posedge clk);
      #1;
      if (rnd_ready3) ready3 = ($urandom_range(0, 3) != 0);
      c++;
    end
    checks++;
    if ((which ? exp1.size() : exp3.size()) != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d beats left expected 0", nm,
               which ? exp1.size() : exp3.size());
      exp1.delete();
      exp3.delete();
    end
  endtask

  // Monitor for the N=8 instance.
  always @(negedge clk) begin
    beat_t a, e;
    if (!rst) begin
      a.u = 8'(u3); a.v = 8'(v3); a.idx = 16'(idx3); a.last = last3;
      if (stall3 && valid3) begin
        checks++;
        if (a !== held3) begin
          errors++;
          $display("FAIL stall3: got idx=%0d u=%0d v=%0d expected idx=%0d u=%0d v=%0d",
                   a.idx, a.u, a.v, held3.idx, held3.u, held3.v);
        end
      end
      if (valid3 && ready3 && !abort3) begin
        checks++;
        if (exp3.size() == 0) begin
          errors++;
          $display("FAIL sb3: got idx=%0d u=%0d v=%0d expected no beat",
                   a.idx, a.u, a.v);
        end else begin
          e = exp3.pop_front();
          if (a !== e) begin
            errors++;
            $display("FAIL sb3: got u=%0d v=%0d idx=%0d last=%0d expected u=%0d v=%0d idx=%0d last=%0d",
                     a.u, a.v, a.idx, a.last, e.u, e.v, e.idx, e.last);
          end
        end
        lu3[idx3] = int'(u3);
        lv3[idx3] = int'(v3);
        seen3[{v3, u3}]++;
      end
      stall3 = valid3 && !ready3 && !abort3;
      held3  = a;
    end else begin
      stall3 = 1'b0;
    end
  end

  // Monitor for the N=2 instance.
  always @(negedge clk) begin
    beat_t a, e;
    if (!rst && valid1 && ready1 && !abort1) begin
      a.u = 8'(u1); a.v = 8'(v1); a.idx = 16'(idx1); a.last = last1;
      checks++;
      if (exp1.size() == 0) begin
        errors++;
        $display("FAIL sb1: got idx=%0d u=%0d v=%0d expected no beat",
                 a.idx, a.u, a.v);
      end else begin
        e = exp1.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL sb1: got u=%0d v=%0d idx=%0d last=%0d expected u=%0d v=%0d idx=%0d last=%0d",
                   a.u, a.v, a.idx, a.last, e.u, e.v, e.idx, e.last);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    beat_t q[$];
    int bad;
    rst = 1'b1;
    start3 = 0; mode3 = 0; abort3 = 0; ready3 = 0;
    start1 = 0; mode1 = 0; abort1 = 0; ready1 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(valid3), 0);
    chk("rst_busy",  int'(busy3), 0);
    chk("rst_done",  int'(done3), 0);
    chk("rst_last",  int'(last3), 0);
    chk("rst_pos",   int'({u3, v3, idx3}), 0);
    rst = 1'b0;

    // raster, no stalls
    push3(1'b0, 64);
    ready3 = 1; mode3 = 0; start3 = 1;
    @(posedge clk); #1;
    start3 = 0;
    chk("raster_first_valid", int'(valid3), 1);
    chk("raster_first_idx", int'(idx3), 0);
    drain(1'b0, 200, "raster");
    chk("raster_done", int'(done3), 1);
    chk("raster_busy_off", int'(busy3), 0);
    chk("raster_hold_idx", int'(idx3), 63);
    chk("raster_hold_uv", int'({u3, v3}), 63);
    chk("raster_last_off", int'(last3), 0);
    chk("raster_idx9_u", lu3[9], 1);
    chk("raster_idx9_v", lv3[9], 1);
    @(posedge clk); #1;
    chk("raster_done_pulse", int'(done3), 0);

    // zigzag with random stalls; mode change mid-walk ignored
    foreach (seen3[i]) seen3[i] = 0;
    push3(ZZ_EN, 64);
    mode3 = 1; start3 = 1;
    @(posedge clk); #1;
    start3 = 0; mode3 = 0;
    rnd_ready3 = 1;
    drain(1'b0, 2000, "zigzag");
    rnd_ready3 = 0; ready3 = 1;
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("scan_idx%0d_u", i), lu3[i], hu[i]);
      chk($sformatf("scan_idx%0d_v", i), lv3[i], hv[i]);
    end
    chk("scan_idx63_uv", lu3[63] * 8 + lv3[63], 63);
    bad = 0;
    foreach (seen3[i]) if (seen3[i] != 1) bad++;
    chk("scan_coverage", bad, 0);
    repeat (2) @(posedge clk);

    // abort at idx 20 together with ready
    push3(1'b0, 20);
    mode3 = 0; start3 = 1;
    @(posedge clk); #1;
    start3 = 0;
    for (int c = 0; c < 100 && idx3 != 6'd20; c++) begin
      @(posedge clk); #1;
    end
    abort3 = 1;
    @(posedge clk); #1;
    abort3 = 0;
    chk("abort_busy", int'(busy3), 0);
    chk("abort_valid", int'(valid3), 0);
    chk("abort_idx", int'(idx3), 20);
    chk("abort_u", int'(u3), 4);
    chk("abort_v", int'(v3), 2);
    chk("abort_drained", exp3.size(), 0);
    bad = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done3) bad++;
    end
    chk("abort_no_done", bad, 0);

    // start held through a walk, then accepted in the done cycle
    push3(1'b0, 64);
    start3 = 1;
    drain(1'b0, 200, "held");
    chk("held_done", int'(done3), 1);
    push3(1'b0, 64);
    @(posedge clk); #1;
    start3 = 0;
    chk("restart_valid", int'(valid3), 1);
    chk("restart_busy", int'(busy3), 1);
    chk("restart_pos", int'({u3, v3, idx3}), 0);
    drain(1'b0, 200, "restart");
    chk("restart_done", int'(done3), 1);

    // reset mid-walk
    push3(1'b0, 5);
    start3 = 1;
    @(posedge clk); #1;
    start3 = 0;
    for (int c = 0; c < 50 && idx3 != 6'd5; c++) begin
      @(posedge clk); #1;
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("midrst_valid", int'(valid3), 0);
    chk("midrst_idx", int'(idx3), 0);
    chk("midrst_drained", exp3.size(), 0);
    @(posedge clk); #1;
    chk("midrst_no_done", int'(done3), 0);

    // N = 2 block, mode = 1
    gen(1, ZZ_EN, 4, q);
    foreach (q[i]) exp1.push_back(q[i]);
    mode1 = 1; ready1 = 1; start1 = 1;
    @(posedge clk); #1;
    start1 = 0;
    drain(1'b1, 50, "n2");
    chk("n2_done", int'(done1), 1);
    chk("n2_hold_uv", int'({u1, v1}), 3);
    chk("n2_busy_off", int'(busy1), 0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
